// File: rtl/ps2_pkg.sv
// Shared constants, state types and the scan-code to ASCII map for the
// PS/2 keyboard front end (scan code set 2, US layout).
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] ASC_ENTER = 8'd13;
  localparam logic [7:0] ASC_BACK  = 8'd8;
  localparam logic [7:0] ASC_SPACE = 8'd32;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_NORM,
    DEC_BRK,
    DEC_EXT,
    DEC_EXT_BRK
  } dec_state_t;

  // Returns {valid, ascii}. Letters are stored lowercase and folded to
  // uppercase when shift XOR caps; digits only respond to shift.
  function automatic logic [8:0] map_code(input logic [7:0] code,
                                          input logic       shift,
                                          input logic       caps);
    logic [7:0] lc;
    logic       is_letter;
    lc        = 8'h00;
    is_letter = 1'b1;
    map_code  = 9'h000;
    case (code)
      8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;
      8'h23: lc = 8'h64;  8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;
      8'h34: lc = 8'h67;  8'h33: lc = 8'h68;  8'h43: lc = 8'h69;
      8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
      8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;
      8'h4D: lc = 8'h70;  8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;
      8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;  8'h3C: lc = 8'h75;
      8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
      8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
      default: is_letter = 1'b0;
    endcase
    if (is_letter) begin
      map_code = {1'b1, (shift ^ caps) ? (lc - 8'h20) : lc};
    end else begin
      case (code)
        8'h16:    map_code = {1'b1, shift ? 8'h21 : 8'h31};
        8'h1E:    map_code = {1'b1, shift ? 8'h40 : 8'h32};
        8'h26:    map_code = {1'b1, shift ? 8'h23 : 8'h33};
        8'h25:    map_code = {1'b1, shift ? 8'h24 : 8'h34};
        8'h2E:    map_code = {1'b1, shift ? 8'h25 : 8'h35};
        8'h36:    map_code = {1'b1, shift ? 8'h5E : 8'h36};
        8'h3D:    map_code = {1'b1, shift ? 8'h26 : 8'h37};
        8'h3E:    map_code = {1'b1, shift ? 8'h2A : 8'h38};
        8'h46:    map_code = {1'b1, shift ? 8'h28 : 8'h39};
        8'h45:    map_code = {1'b1, shift ? 8'h29 : 8'h30};
        SC_SPACE: map_code = {1'b1, ASC_SPACE};
        SC_ENTER: map_code = {1'b1, ASC_ENTER};
        SC_BKSP:  map_code = {1'b1, ASC_BACK};
        default:  map_code = 9'h000;
      endcase
    end
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the raw lines, shifts in
// start/8 data/odd parity/stop, and aborts a stalled frame after
// TIMEOUT_CYC cycles without a falling edge.
//
// state     | meaning
// ----------+----------------------------------------------
// RX_IDLE   | waiting for a start bit
// RX_DATA   | shifting in data bits, LSB first
// RX_PARITY | capturing the odd-parity bit
// RX_STOP   | checking the stop bit, strobing the byte if good
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       frame_err
);

  localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic            clk_s1, clk_s2, clk_d;
  logic            dat_s1, dat_s2;
  logic            fall;
  rx_state_t       state_q, state_d;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shreg_q;
  logic            par_q;
  logic [TW-1:0]   tmo_q;
  logic            tmo_hit;
  logic            parity_ok;

  // Two-flop synchronisers; lines reset high (idle) so release makes no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall      = clk_d & ~clk_s2;
  assign tmo_hit   = (state_q != RX_IDLE) && (tmo_q == TMO_LAST);
  assign parity_ok = ^{shreg_q, par_q};
  assign rx_byte   = shreg_q;

  // State register, data shifter, bit counter and inactivity counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (fall && state_q == RX_DATA) begin
        shreg_q   <= {dat_s2, shreg_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end else if (state_q == RX_IDLE) begin
        bit_cnt_q <= 3'd0;
      end
      if (fall && state_q == RX_PARITY) par_q <= dat_s2;
      if (state_d == RX_IDLE || fall) tmo_q <= '0;
      else                            tmo_q <= tmo_q + TW'(1);
    end
  end

  // Next-state and strobe generation; an edge takes precedence over timeout.
  always_comb begin
    state_d   = state_q;
    byte_stb  = 1'b0;
    frame_err = 1'b0;
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (dat_s2) frame_err = 1'b1;
          else        state_d   = RX_DATA;
        end
        RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        RX_PARITY: state_d = RX_STOP;
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dat_s2 && parity_ok) byte_stb  = 1'b1;
          else                     frame_err = 1'b1;
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d   = RX_IDLE;
      frame_err = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_ascii.sv
// PS/2 keyboard to ASCII front end: receives scan-code bytes, tracks
// break/extended prefixes, shift, caps lock and the held key, and emits
// one ASCII byte per key press with a single-cycle p_valid.
// Build option: define PS2_AUTOREPEAT_EN to emit typematic repeats.
//
// state       | meaning
// ------------+------------------------------------------
// DEC_NORM    | next byte is a make code or a prefix
// DEC_BRK     | after 0xF0, next byte is a released key
// DEC_EXT     | after 0xE0, next byte is an extended make
// DEC_EXT_BRK | after 0xE0 0xF0, next byte is dropped
module ps2_ascii
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_out,
  output logic       p_valid,
  output logic       caps_on,
  output logic       frame_err
);

`ifdef PS2_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic [7:0] rx_byte;
  logic       byte_stb;
  dec_state_t dec_q, dec_d;
  logic       shift_q, shift_d;
  logic       caps_d;
  logic       held_q, held_d;
  logic [7:0] last_q, last_d;
  logic       emit;
  logic [7:0] emit_code;
  logic [8:0] mapped;
  logic       is_shift;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_stb  (byte_stb),
    .frame_err (frame_err)
  );

  // Decoder state, modifier flags and the registered character output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_q   <= DEC_NORM;
      shift_q <= 1'b0;
      caps_on <= 1'b0;
      held_q  <= 1'b0;
      last_q  <= 8'h00;
      key_out <= 8'h00;
      p_valid <= 1'b0;
    end else begin
      p_valid <= byte_stb & emit;
      if (byte_stb) begin
        dec_q   <= dec_d;
        shift_q <= shift_d;
        caps_on <= caps_d;
        held_q  <= held_d;
        last_q  <= last_d;
        if (emit) key_out <= emit_code;
      end
    end
  end

  // Interprets the current byte against the prefix state and flags.
  always_comb begin
    dec_d     = dec_q;
    shift_d   = shift_q;
    caps_d    = caps_on;
    held_d    = held_q;
    last_d    = last_q;
    emit      = 1'b0;
    emit_code = 8'h00;
    is_shift  = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);
    mapped    = map_code(rx_byte, shift_q, caps_on);
    case (dec_q)
      DEC_NORM: begin
        if (rx_byte == SC_BREAK) begin
          dec_d = DEC_BRK;
        end else if (rx_byte == SC_EXT) begin
          dec_d = DEC_EXT;
        end else begin
          if (is_shift) shift_d = 1'b1;
          // The held flag keeps typematic caps repeats from re-toggling.
          if (rx_byte == SC_CAPS) begin
            if (!held_q) caps_d = ~caps_on;
            held_d = 1'b1;
          end
          last_d    = rx_byte;
          emit      = mapped[8] && (AUTOREPEAT || (rx_byte != last_q));
          emit_code = mapped[7:0];
        end
      end
      DEC_BRK: begin
        if (is_shift)             shift_d = 1'b0;
        if (rx_byte == SC_CAPS)   held_d  = 1'b0;
        if (rx_byte == last_q)    last_d  = 8'h00;
        dec_d = DEC_NORM;
      end
      DEC_EXT: begin
        if (rx_byte == SC_ENTER) begin
          emit      = 1'b1;
          emit_code = ASC_ENTER;
        end
        dec_d = (rx_byte == SC_BREAK) ? DEC_EXT_BRK : DEC_NORM;
      end
      DEC_EXT_BRK: dec_d = DEC_NORM;
      default:     dec_d = DEC_NORM;
    endcase
  end

endmodule

// File: tb/tb_ps2_ascii.sv
// Scoreboard bench for ps2_ascii: a keyboard-level model pushes expected
// characters into a queue; a monitor pops and compares on every p_valid.
module tb_ps2_ascii;

  localparam int T    = 300;
  localparam int HALF = 8;
  localparam int GAP  = 20;

`ifdef PS2_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_out;
  logic       p_valid, caps_on, frame_err;

  ps2_ascii #(.TIMEOUT_CYC(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_out   (key_out),
    .p_valid   (p_valid),
    .caps_on   (caps_on),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int pv_seen = 0, err_seen = 0, exp_err = 0;
  logic [7:0] exp_q[$];

  // Keyboard model state
  bit m_brk, m_ext, m_ext_brk, m_shift, m_caps, m_held;
  logic [7:0] m_last;

  logic [7:0] let_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                             8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                             8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                             8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_sc[10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                             8'h3E, 8'h46, 8'h45};
  string dig_plain = "1234567890";
  string dig_shift = "!@#$%^&*()";
  logic [7:0] pool[20] = '{8'h1C, 8'h32, 8'h21, 8'h24, 8'h15, 8'h1A, 8'h16,
                           8'h1E, 8'h45, 8'h3E, 8'h29, 8'h5A, 8'h66, 8'h12,
                           8'h59, 8'h58, 8'h0E, 8'h14, 8'h2B, 8'h4D};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int ascii_of(input logic [7:0] sc, input bit sh, input bit cp);
    for (int i = 0; i < 26; i++)
      if (let_sc[i] == sc) return ((sh ^ cp) ? 65 : 97) + i;
    for (int i = 0; i < 10; i++)
      if (dig_sc[i] == sc) return sh ? int'(dig_shift[i]) : int'(dig_plain[i]);
    if (sc == 8'h29) return 32;
    if (sc == 8'h5A) return 13;
    if (sc == 8'h66) return 8;
    return -1;
  endfunction

  task automatic m_reset();
    m_brk = 0; m_ext = 0; m_ext_brk = 0;
    m_shift = 0; m_caps = 0; m_held = 0; m_last = 8'h00;
  endtask

  // What a keyboard user expects from one received byte.
  task automatic model_byte(input logic [7:0] b);
    int a;
    bit rep;
    if (m_brk) begin
      m_brk = 0;
      if (b == 8'h12 || b == 8'h59) m_shift = 0;
      if (b == 8'h58) m_held = 0;
      if (b == m_last) m_last = 8'h00;
    end else if (m_ext_brk) begin
      m_ext_brk = 0;
    end else if (m_ext) begin
      m_ext = 0;
      if (b == 8'hF0) m_ext_brk = 1;
      else if (b == 8'h5A) exp_q.push_back(8'd13);
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      a   = ascii_of(b, m_shift, m_caps);
      rep = (b == m_last);
      m_last = b;
      if (b == 8'h12 || b == 8'h59) m_shift = 1;
      if (b == 8'h58) begin
        if (!m_held) m_caps = ~m_caps;
        m_held = 1;
      end
      if (a >= 0 && (AR || !rep)) exp_q.push_back(8'(a));
    end
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = {(kind == 2) ? 1'b0 : 1'b1, (kind == 1) ? (^b) : ~(^b), b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    cyc(GAP);
  endtask

  task automatic good(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 0);
    chk("caps_on", caps_on, m_caps);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
  endtask

  // Scoreboard monitor
  initial begin
    logic pv_prev, fe_prev;
    pv_prev = 0;
    fe_prev = 0;
    forever begin
      @(negedge clk);
      if (p_valid) begin
        pv_seen++;
        chk("p_valid width", pv_prev, 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_p_valid: key_out=%02h with no character expected", key_out);
        end else begin
          chk("key_out", key_out, exp_q.pop_front());
        end
      end
      if (frame_err) begin
        err_seen++;
        chk("frame_err width", fe_prev, 0);
        chk("p_valid with frame_err", p_valid, 0);
      end
      pv_prev = p_valid;
      fe_prev = frame_err;
    end
  end

  initial begin
    int pv0, e0, cnt;
    m_reset();
    cyc(4);
    chk("reset key_out", key_out, 8'h00);
    chk("reset p_valid", p_valid, 0);
    chk("reset caps_on", caps_on, 0);
    chk("reset frame_err", frame_err, 0);
    reset = 1'b0;
    cyc(10);

    // single letter
    pv0 = pv_seen; e0 = err_seen;
    good(8'h1C);
    chk("t1 count", pv_seen - pv0, 1);
    chk("t1 key", key_out, 8'h61);
    chk("t1 err", err_seen - e0, 0);

    // shift make/break
    pv0 = pv_seen;
    good(8'h12); good(8'h1C); good(8'hF0); good(8'h1C);
    good(8'hF0); good(8'h12); good(8'h1C);
    chk("t2 count", pv_seen - pv0, 2);
    chk("t2 key", key_out, 8'h61);

    // caps lock, shifted digit
    good(8'h58); good(8'hF0); good(8'h58); good(8'h1C);
    chk("t3 caps", caps_on, 1);
    chk("t3 key", key_out, 8'h41);
    good(8'h12); good(8'h16);
    chk("t3 bang", key_out, 8'h21);
    good(8'hF0); good(8'h12);

    // enter, backspace, keypad enter
    pv0 = pv_seen;
    good(8'h5A); good(8'h66); good(8'hE0); good(8'h5A);
    chk("t4 count", pv_seen - pv0, 3);
    chk("t4 key", key_out, 8'd13);

    // bad parity then space
    pv0 = pv_seen; e0 = err_seen;
    exp_err++;
    send_frame(8'h1C, 1);
    chk("t5 err", err_seen - e0, 1);
    chk("t5 no pv", pv_seen - pv0, 0);
    good(8'h29);
    chk("t5 space", key_out, 8'h20);

    // stall after 4 data bits; frame_err lands two synchroniser cycles
    // plus TIMEOUT_CYC cycles after the raw edge
    send_partial(3);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    exp_err++;
    for (cnt = 1; cnt <= 2 * T; cnt++) begin
      @(negedge clk);
      if (frame_err) break;
    end
    chk("timeout latency", cnt, T + 2);
    ps2_clk = 1'b1;
    cyc(GAP);
    good(8'h1C);
    chk("post-timeout key", key_out, 8'h41);

    // reset mid-frame
    pv0 = pv_seen; e0 = err_seen;
    send_partial(3);
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(3);
    chk("midrst key_out", key_out, 8'h00);
    chk("midrst caps_on", caps_on, 0);
    chk("midrst p_valid", p_valid, 0);
    chk("midrst frame_err", frame_err, 0);
    m_reset();
    reset = 1'b0;
    cyc(2 * T);
    chk("midrst no pv", pv_seen - pv0, 0);
    chk("midrst no err", err_seen - e0, 0);

    // randomized key traffic
    for (int it = 0; it < 50; it++) begin
      int r;
      logic [7:0] k;
      r = $urandom_range(0, 11);
      k = pool[$urandom_range(0, 19)];
      if (r <= 4) begin
        good(k);
      end else if (r <= 6) begin
        good(8'hF0); good(k);
      end else if (r == 7) begin
        good(k); good(k);
      end else if (r == 8) begin
        good(8'hE0); good(8'h5A);
      end else if (r == 9) begin
        good(8'hE0); good(8'hF0); good(8'h5A);
      end else if (r == 10) begin
        exp_err++;
        send_frame(k, $urandom_range(1, 2));
      end else begin
        exp_err++;
        ps2_bit(1'b1);
        cyc(GAP);
      end
    end

    cyc(GAP);
    chk("queue drained", exp_q.size(), 0);
    chk("frame_err total", err_seen, exp_err);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_ascii.md
# ps2_ascii

Keyboard front end for the text-mode terminal. It samples the raw PS/2 clock and data lines and receives scan-code frames. It tracks make, break, shift and caps-lock state, then emits one ASCII byte with a one-cycle valid strobe per key press. Its outputs drive the video-memory stage's `key_in`/`p_valid` inputs directly, so it also emits the control codes that stage acts on: Enter = 13, Backspace = 8.

## Interface
- `TIMEOUT_CYC`, default 50000: mid-frame inactivity limit in `clk` cycles (1 ms at 50 MHz).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `key_out`  out  8  ASCII code; valid only while `p_valid` is high.
- `p_valid`  out  1  one-cycle strobe, one per accepted character.
- `caps_on`  out  1  caps-lock state.
- `frame_err`  out  1  one-cycle strobe on a parity, start or stop error, or on timeout.

## Operation
- Synchronisation: `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. A falling edge means the synchronised clock was 1 on the previous cycle and 0 now. Data is sampled on that cycle.
- Receiver FSM: IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: a falling edge with data 0 is a start bit; go to DATA. A falling edge with data 1 is a start error: pulse `frame_err`, stay in IDLE.
  - DATA: 8 bits, LSB first, counted 0..7 with a 3-bit counter.
  - PARITY: the parity bit must make the total of the 8 data bits plus parity odd.
  - STOP: the stop bit must be 1. A good frame pulses the internal `byte_stb` with `byte` valid. A bad parity or stop bit pulses `frame_err` and drops the byte. Either way the FSM returns to IDLE.
- Timeout: in any state other than IDLE, a counter increments every cycle and clears on each falling edge. When it reaches `TIMEOUT_CYC - 1` the FSM goes to IDLE and pulses `frame_err`.
- Decoder FSM: NORM, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (0xE0 then 0xF0).
  - In NORM, 0xF0 → BRK and 0xE0 → EXT. Any other byte is a make code.
  - BRK: the next byte is a break code; clear the shift flag if it is 0x12 or 0x59; go to NORM.
  - EXT: the next byte is an extended make. 0x5A (keypad Enter) emits 13; anything else emits nothing. 0xF0 → EXT_BRK; any other byte → NORM.
  - EXT_BRK: the next byte is consumed with no output; go to NORM.
- Shift: the flag sets on make 0x12 or 0x59 and clears on the matching break.
- Caps lock: 0x58 make toggles `caps_on`, but only if 0x58 is not already held. A separate held flag clears on the 0x58 break.
- Held key: `last_make` holds the last make code and is cleared by that code's break. It is used by the configuration feature.
- Map (US layout):
  - Letters: lowercase 0x61–0x7A; uppercase 0x41–0x5A when shift XOR `caps_on`.
  - Digit row: 0–9 unshifted; `!@#$%^&*()` with shift. Caps lock does not affect digits.
  - Fixed keys: space 0x29 → 32, Enter 0x5A → 13, Backspace 0x66 → 8.
  - Every other code, including modifiers, produces no output.
- Reset values: receiver in IDLE, decoder in NORM, all counters 0, shift 0, `caps_on` 0, `key_out` 0x00, `p_valid` 0, `frame_err` 0.
- Reset mid-frame: the partial frame is discarded and there is no strobe after release.

## Timing
- Let N be the cycle on which the synchronised falling edge of the stop bit is detected. `byte_stb` is combinational at N. `key_out` and `p_valid` are registered at N+1.
- Latency from a raw `ps2_clk` fall to `p_valid`: 3–4 `clk` cycles, including synchroniser delay.
- `p_valid` and `frame_err` are always exactly one cycle wide and are never high together.
- At most one character per frame. Frames arrive at least ~600 µs apart, so there is no back-pressure and no buffering.
- `key_out` holds its value between strobes.

## Configuration
- `PS2_AUTOREPEAT_EN` defined: a make code equal to `last_make` (typematic repeat) emits the character again on every repeat.
- `PS2_AUTOREPEAT_EN` not defined: a repeated make code equal to `last_make` is suppressed. One character is emitted per physical press.
- Caps-lock toggling never auto-repeats, whether or not the macro is defined.

## Structure
- Package `ps2_pkg` holds:
  - scan-code constants `SC_BREAK` = 0xF0, `SC_EXT` = 0xE0, `SC_LSHIFT`, `SC_RSHIFT`, `SC_CAPS`, `SC_ENTER`, `SC_BKSP`, `SC_SPACE`;
  - ASCII constants `ASC_ENTER` = 13, `ASC_BACK` = 8;
  - the receiver and decoder state enums.
- Sub-module `ps2_rx` contains the synchronisers, receiver FSM and timeout counter. It outputs `byte`, `byte_stb` and `frame_err`.
- The top level contains the decoder FSM, the modifier flags and the map. The map is a combinational case function in `ps2_pkg`.

## Test plan
- Send frame 0x1C → exactly one `p_valid` with `key_out` = 0x61; no `frame_err`.
- Send 0x12, 0x1C, 0xF0 0x1C, 0xF0 0x12, then 0x1C → outputs 0x41 then 0x61. Neither break sequence produces a strobe.
- Send 0x58, 0xF0 0x58, 0x1C → `caps_on` = 1 and the output is 0x41. Send 0x12 then 0x16 → 0x21 (`!`).
- Send 0x5A, 0x66, then extended 0xE0 0x5A → outputs 13, 8, 13.
- Corrupt the parity bit of 0x1C → one `frame_err` pulse and no `p_valid`. A following good 0x29 → 0x20.
- Stop `ps2_clk` after 4 data bits → `frame_err` exactly `TIMEOUT_CYC` cycles after the last edge, and the next good frame decodes. Assert `reset` mid-frame → all outputs return to their reset values and nothing is emitted.
